// File: rtl/dma_2d_loader_if.sv
// dma_2d_loader_if: AXI4 read address/data channels between the loader DMA and DDR
interface dma_2d_loader_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/dma_2d_loader.sv
// dma_2d_loader: 2D strided DDR->SRAM load DMA over AXI4 reads, one outstanding burst
// Define DMA_2D_4K_SPLIT_EN to also clip bursts at 4KB DDR boundaries.
module dma_2d_loader #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int BURST_LEN       = 16,
    parameter int DIM_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    input  logic [ADDR_WIDTH-1:0]      ddr_addr,
    input  logic [ADDR_WIDTH-1:0]      ddr_stride,
    input  logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0] sram_stride,
    input  logic [DIM_WIDTH-1:0]       row_beats,
    input  logic [DIM_WIDTH-1:0]       row_count,
    dma_2d_loader_if.master            m_axi,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_out,
    output logic [AXI_DATA_WIDTH-1:0]  sram_wdata,
    output logic                       sram_we
);
    localparam int SZ = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CW = (DIM_WIDTH > 13 ? DIM_WIDTH : 13) + 1;
    localparam logic [ADDR_WIDTH-1:0] AMASK = {ADDR_WIDTH{1'b1}} << SZ;
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
    state_t                     state;
    logic [ADDR_WIDTH-1:0]      ddr_row, ddr_stride_r, n_ptr;
    logic [SRAM_ADDR_WIDTH-1:0] sram_row, sram_stride_r, sram_ptr;
    logic [DIM_WIDTH-1:0]       row_beats_r, rows_left, beats_left, n_left;
    logic [8:0]                 beat_cnt;
    logic [CW-1:0]              lim, n_beats;
    logic                       row_end, last_row, beat_err;
`ifdef DMA_2D_4K_SPLIT_EN
    logic [CW-1:0]              to_4k;
`endif
    assign m_axi.arsize  = 3'(SZ);
    assign m_axi.arburst = 2'b01;
    assign sram_we       = m_axi.rready & m_axi.rvalid;
    assign sram_wdata    = m_axi.rdata;
    assign sram_addr_out = sram_ptr;
    // Next burst start: tile base from IDLE, next row base at row end, else continue the row.
    always_comb begin
        row_end  = beats_left == '0;
        last_row = rows_left == DIM_WIDTH'(1);
        beat_err = m_axi.rresp != 2'b00 || m_axi.rlast != (beat_cnt == 9'd1);
        n_ptr    = state == IDLE ? ddr_addr & AMASK :
                   row_end ? ddr_row + ddr_stride_r :
                   m_axi.araddr + ((ADDR_WIDTH'(m_axi.arlen) + ADDR_WIDTH'(1)) << SZ);
        n_left   = state == IDLE ? row_beats : row_end ? row_beats_r : beats_left;
        lim      = CW'(n_left) < CW'(BURST_LEN) ? CW'(n_left) : CW'(BURST_LEN);
`ifdef DMA_2D_4K_SPLIT_EN
        to_4k    = CW'((13'h1000 - {1'b0, n_ptr[11:0]}) >> SZ);
        n_beats  = to_4k < lim ? to_4k : lim;
`else
        n_beats  = lim;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            m_axi.arvalid  <= 1'b0;
            m_axi.rready   <= 1'b0;
            m_axi.araddr   <= '0;
            m_axi.arlen    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy          <= 1'b1;
                    error         <= 1'b0;
                    ddr_row       <= ddr_addr & AMASK;
                    ddr_stride_r  <= ddr_stride & AMASK;
                    sram_row      <= sram_addr;
                    sram_ptr      <= sram_addr;
                    sram_stride_r <= sram_stride;
                    row_beats_r   <= row_beats;
                    rows_left     <= row_count;
                    if (row_beats == '0 || row_count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= AR;
                        m_axi.arvalid <= 1'b1;
                        m_axi.araddr  <= n_ptr;
                        m_axi.arlen   <= 8'(n_beats - CW'(1));
                        beats_left    <= n_left - DIM_WIDTH'(n_beats);
                    end
                end
                AR: if (m_axi.arready) begin
                    state         <= R;
                    m_axi.arvalid <= 1'b0;
                    m_axi.rready  <= 1'b1;
                    beat_cnt      <= 9'(m_axi.arlen) + 9'd1;
                end
                R: if (m_axi.rvalid) begin
                    sram_ptr <= sram_ptr + SRAM_ADDR_WIDTH'(1);
                    beat_cnt <= beat_cnt - 9'(beat_cnt != 9'd0);
                    if (beat_err) error <= 1'b1;
                    if (m_axi.rlast) begin
                        m_axi.rready <= 1'b0;
                        if (row_end) begin
                            rows_left <= rows_left - DIM_WIDTH'(1);
                            ddr_row   <= n_ptr;
                            sram_row  <= sram_row + sram_stride_r;
                            sram_ptr  <= sram_row + sram_stride_r;
                        end
                        if (error || beat_err || (row_end && last_row)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= AR;
                            m_axi.arvalid <= 1'b1;
                            m_axi.araddr  <= n_ptr;
                            m_axi.arlen   <= 8'(n_beats - CW'(1));
                            beats_left    <= n_left - DIM_WIDTH'(n_beats);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
